// File: rtl/multicycle_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control FSM.
// Holds the state encoding, the decoded opcode values and the datapath mux
// select codes, so the controller and anything observing it agree on them.
package mips_ctrl_pkg;

  // State encoding is visible on the debug 'state' port, so values are fixed.
  typedef enum logic [3:0] {
    ST_INIT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BRANCH = 4'd9,
    ST_JUMP   = 4'd10,
    ST_ADDIEX = 4'd11,
    ST_ADDIWB = 4'd12,
    ST_JAL    = 4'd13
  } state_t;

  // Opcodes (IR[31:26]) understood by the controller
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // mem_to_reg: writeback source
  localparam logic [1:0] MTR_ALUOUT = 2'b00;
  localparam logic [1:0] MTR_MDR    = 2'b01;
  localparam logic [1:0] MTR_PC     = 2'b10;

  // reg_dst: destination register
  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  // alu_src_b: second ALU operand
  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // alu_op: request to the ALU-control block
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // pc_source: next-PC source
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States in which the controller waits on the unified memory
  function automatic logic is_mem_wait(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multicycle controller and the datapath/memory.
//   opcode, mem_ready           : datapath/memory -> controller
//   pc_write .. pc_source       : controller -> datapath mux selects/enables
//   instr_done, illegal_op,
//   mem_err                     : controller status pulses
//   state                       : current FSM state (debug)
// modport master: the controller side; modport slave: the datapath side.
interface multicycle_ctrl_if;
  logic [5:0] opcode;
  logic       mem_ready;

  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic [1:0] mem_to_reg;
  logic [1:0] reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;
  logic       instr_done;
  logic       illegal_op;
  logic       mem_err;
  logic [3:0] state;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_err, state
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source, instr_done, illegal_op, mem_err, state
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath.
// Steps each instruction through fetch/decode/execute/memory/writeback and
// drives every datapath select and enable. Memory states wait on mem_ready;
// a wait counter aborts a stuck access back to FETCH with a mem_err pulse.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (returns to INIT)
//   bus    : multicycle_ctrl_if.master (opcode/mem_ready in, controls out)
// Parameter:
//   MEM_TIMEOUT : cycles allowed per memory wait, 0 = never time out (0..255)
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  multicycle_ctrl_if.master   bus
);
  import mips_ctrl_pkg::*;

  localparam bit         TIMEOUT_EN   = (MEM_TIMEOUT != 0);
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t     state_q;
  state_t     state_d;
  logic [7:0] wait_cnt;
  logic       waiting;
  logic       timeout;

  // Counter runs only while stalled on memory; timeout fires on the last
  // permitted stall cycle, and a same-cycle mem_ready still wins.
  assign waiting = is_mem_wait(state_q) && !bus.mem_ready;
  assign timeout = TIMEOUT_EN && waiting && (wait_cnt == TIMEOUT_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Timeout re-enters FETCH without a state change, so it clears the count
  // explicitly. With timeouts disabled the count is free to wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wait_cnt <= 8'd0;
    end else if (!waiting || timeout || (state_d != state_q)) begin
      wait_cnt <= 8'd0;
    end else begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign bus.state = state_q;

  always_comb begin
    state_d           = state_q;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.i_or_d        = 1'b0;
    bus.mem_read      = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.mem_to_reg    = MTR_ALUOUT;
    bus.reg_dst       = DST_RT;
    bus.reg_write     = 1'b0;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REGB;
    bus.alu_op        = ALUOP_ADD;
    bus.pc_source     = PCSRC_ALU;
    bus.instr_done    = 1'b0;
    bus.illegal_op    = 1'b0;
    bus.mem_err       = 1'b0;

    case (state_q)
      ST_INIT: state_d = ST_FETCH;

      // PC+4 is computed here; IR and PC load only when the fetch completes
      ST_FETCH: begin
        bus.mem_read  = 1'b1;
        bus.i_or_d    = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_op    = ALUOP_ADD;
        bus.pc_source = PCSRC_ALU;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) begin
          state_d = ST_DECODE;
        end else if (timeout) begin
          bus.mem_err = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      // Branch target is precomputed speculatively while decoding
      ST_DECODE: begin
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = SRCB_IMM_SH2;
        bus.alu_op    = ALUOP_ADD;
        case (bus.opcode)
          OP_RTYPE:     state_d = ST_EXEC;
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_JAL:       state_d = ST_JAL;
          OP_ADDI:      state_d = ST_ADDIEX;
          default: begin
            bus.illegal_op = 1'b1;
            state_d        = ST_FETCH;
          end
        endcase
      end

      ST_MEMADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_ADD;
        state_d       = (bus.opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      end

      ST_MEMRD: begin
        bus.mem_read = 1'b1;
        bus.i_or_d   = 1'b1;
        if (bus.mem_ready) begin
          state_d = ST_MEMWB;
        end else if (timeout) begin
          bus.mem_err = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      ST_MEMWB: begin
        bus.reg_dst    = DST_RT;
        bus.mem_to_reg = MTR_MDR;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_MEMWR: begin
        bus.mem_write = 1'b1;
        bus.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          bus.instr_done = 1'b1;
          state_d        = ST_FETCH;
        end else if (timeout) begin
          bus.mem_err = 1'b1;
          state_d     = ST_FETCH;
        end
      end

      ST_EXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_REGB;
        bus.alu_op    = ALUOP_FUNCT;
        state_d       = ST_ALUWB;
      end

      ST_ALUWB: begin
        bus.reg_dst    = DST_RD;
        bus.mem_to_reg = MTR_ALUOUT;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_src_b     = SRCB_REGB;
        bus.alu_op        = ALUOP_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_source     = PCSRC_ALUOUT;
        bus.instr_done    = 1'b1;
        state_d           = ST_FETCH;
      end

      ST_JUMP: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = PCSRC_JUMP;
        bus.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      // PC already holds PC+4 from FETCH, so it is the link value
      ST_JAL: begin
        bus.pc_write   = 1'b1;
        bus.pc_source  = PCSRC_JUMP;
        bus.reg_write  = 1'b1;
        bus.reg_dst    = DST_RA;
        bus.mem_to_reg = MTR_PC;
        bus.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      ST_ADDIEX: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = ALUOP_ADD;
        state_d       = ST_ADDIWB;
      end

      ST_ADDIWB: begin
        bus.reg_dst    = DST_RT;
        bus.mem_to_reg = MTR_ALUOUT;
        bus.reg_write  = 1'b1;
        bus.instr_done = 1'b1;
        state_d        = ST_FETCH;
      end

      default: state_d = ST_INIT;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench for multicycle_ctrl (MEM_TIMEOUT = 4).
// The driver plans each instruction from the opcode and the memory wait
// lengths, pushes the expected per-instruction outcome and per-cycle state
// sequence, then plays the input schedule. The monitor accumulates what the
// DUT did and compares when an instruction ends (instr_done/illegal_op/mem_err).
module tb_multicycle_ctrl;
  import mips_ctrl_pkg::*;

  localparam int TO     = 4;
  localparam int N_RAND = 300;

  typedef struct {
    int cycles;
    int ir_w;
    int pc_w;
    int pc_wc;
    int reg_w;
    int mem_r;
    int mem_w;
    int end_kind;
    int wb_dst;
    int wb_src;
    int excl;
  } summ_t;

  logic clk = 1'b0;
  logic rst_n;
  bit   running = 1'b0;

  int n_cmp  = 0;
  int n_fail = 0;

  summ_t      exp_q[$];
  int         st_exp_q[$];
  bit         sched_rdy[$];
  logic [5:0] sched_op[$];
  summ_t      acc;

  multicycle_ctrl_if bus();

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic bit is_legal(input logic [5:0] o);
    return o == OP_RTYPE || o == OP_LW || o == OP_SW || o == OP_BEQ ||
           o == OP_J || o == OP_JAL || o == OP_ADDI;
  endfunction

  function automatic int all_outputs();
    return int'({bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
                 bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
                 bus.pc_source, bus.instr_done, bus.illegal_op, bus.mem_err});
  endfunction

  function automatic summ_t blank();
    summ_t s;
    s = '{default: 0};
    return s;
  endfunction

  task automatic push_cycle(input bit r, input int st, input logic [5:0] o);
    sched_rdy.push_back(r);
    sched_op.push_back(o);
    st_exp_q.push_back(st);
  endtask

  // A memory access stalled w cycles; returns 1 if it exceeds the timeout
  task automatic mem_phase(input int w, input int st, input logic [5:0] o,
                           output bit timed_out, output int n);
    timed_out = (TO != 0) && (w >= TO);
    n = timed_out ? TO : w + 1;
    for (int i = 0; i < n; i++) push_cycle((!timed_out && i == w), st, o);
  endtask

  task automatic apply_stimulus(input logic [5:0] op, input int f, input int m);
    summ_t e;
    bit    tmo;
    int    n;
    e = blank();
    mem_phase(f, int'(ST_FETCH), 6'($urandom_range(0, 63)), tmo, n);
    e.mem_r = n;
    if (tmo) begin
      e.end_kind = 2;
    end else begin
      e.ir_w = 1;
      e.pc_w = 1;
      push_cycle(1'($urandom_range(0, 1)), int'(ST_DECODE), op);
      case (op)
        OP_RTYPE: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_EXEC), op);
          push_cycle(1'($urandom_range(0, 1)), int'(ST_ALUWB), op);
          e.reg_w = 1; e.wb_dst = 1; e.wb_src = 0;
        end
        OP_LW: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_MEMADR), op);
          mem_phase(m, int'(ST_MEMRD), op, tmo, n);
          e.mem_r += n;
          if (tmo) e.end_kind = 2;
          else begin
            push_cycle(1'($urandom_range(0, 1)), int'(ST_MEMWB), op);
            e.reg_w = 1; e.wb_dst = 0; e.wb_src = 1;
          end
        end
        OP_SW: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_MEMADR), op);
          mem_phase(m, int'(ST_MEMWR), op, tmo, n);
          e.mem_w = n;
          if (tmo) e.end_kind = 2;
        end
        OP_BEQ: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_BRANCH), op);
          e.pc_wc = 1;
        end
        OP_J: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_JUMP), op);
          e.pc_w += 1;
        end
        OP_JAL: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_JAL), op);
          e.pc_w += 1; e.reg_w = 1; e.wb_dst = 2; e.wb_src = 2;
        end
        OP_ADDI: begin
          push_cycle(1'($urandom_range(0, 1)), int'(ST_ADDIEX), op);
          push_cycle(1'($urandom_range(0, 1)), int'(ST_ADDIWB), op);
          e.reg_w = 1; e.wb_dst = 0; e.wb_src = 0;
        end
        default: e.end_kind = 1;
      endcase
    end
    e.cycles = sched_rdy.size();
    exp_q.push_back(e);
    while (sched_rdy.size() > 0) begin
      bus.mem_ready = sched_rdy.pop_front();
      bus.opcode    = sched_op.pop_front();
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: tally each cycle, compare a whole instruction when it ends
  always @(negedge clk) begin
    if (running) begin
      int ends;
      summ_t e;
      acc.cycles++;
      if (bus.ir_write)      acc.ir_w++;
      if (bus.pc_write)      acc.pc_w++;
      if (bus.pc_write_cond) acc.pc_wc++;
      if (bus.mem_read)      acc.mem_r++;
      if (bus.mem_write)     acc.mem_w++;
      if (bus.reg_write) begin
        acc.reg_w++;
        acc.wb_dst = int'(bus.reg_dst);
        acc.wb_src = int'(bus.mem_to_reg);
      end
      if ((bus.mem_read && bus.mem_write) || (bus.reg_write && bus.mem_write))
        acc.excl++;
      if (st_exp_q.size() == 0) check_output("state_unexpected_cycle", int'(bus.state), -1);
      else check_output("state", int'(bus.state), st_exp_q.pop_front());
      ends = int'(bus.instr_done) + int'(bus.illegal_op) + int'(bus.mem_err);
      if (ends != 0) begin
        acc.end_kind = (ends > 1) ? 3 : bus.instr_done ? 0 : bus.illegal_op ? 1 : 2;
        if (exp_q.size() == 0) begin
          check_output("unexpected_instr_end", acc.end_kind, -1);
        end else begin
          e = exp_q.pop_front();
          check_output("cycles",        acc.cycles,   e.cycles);
          check_output("ir_write_cnt",  acc.ir_w,     e.ir_w);
          check_output("pc_write_cnt",  acc.pc_w,     e.pc_w);
          check_output("pc_wcond_cnt",  acc.pc_wc,    e.pc_wc);
          check_output("reg_write_cnt", acc.reg_w,    e.reg_w);
          check_output("mem_read_cnt",  acc.mem_r,    e.mem_r);
          check_output("mem_write_cnt", acc.mem_w,    e.mem_w);
          check_output("end_kind",      acc.end_kind, e.end_kind);
          check_output("wb_reg_dst",    acc.wb_dst,   e.wb_dst);
          check_output("wb_mem_to_reg", acc.wb_src,   e.wb_src);
          check_output("mutual_excl",   acc.excl,     e.excl);
        end
        acc = blank();
      end
    end
  end

  logic [5:0] dir_op[6] = '{OP_RTYPE, OP_LW, OP_SW, OP_JAL, 6'b111111, OP_ADDI};
  int         dir_f[6]  = '{0, 0, 0, 0, 0, 5};
  int         dir_m[6]  = '{0, 3, 1, 0, 0, 0};
  logic [5:0] legal[7]  = '{OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_JAL, OP_ADDI};

  initial begin
    logic [5:0] op;
    int f, m;
    acc           = blank();
    rst_n         = 1'b0;
    bus.mem_ready = 1'b0;
    bus.opcode    = 6'd0;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset_state", int'(bus.state), 0);
    check_output("reset_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_output("init_state", int'(bus.state), 0);
    check_output("init_outputs", all_outputs(), 0);
    @(posedge clk);
    #1;
    running = 1'b1;

    for (int i = 0; i < 6; i++) apply_stimulus(dir_op[i], dir_f[i], dir_m[i]);

    for (int i = 0; i < N_RAND; i++) begin
      if ($urandom_range(0, 7) == 7) begin
        do op = 6'($urandom_range(0, 63)); while (is_legal(op));
      end else begin
        op = legal[$urandom_range(0, 6)];
      end
      f = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 6)) : 0;
      m = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, 6)) : 0;
      apply_stimulus(op, f, m);
    end
    running = 1'b0;
    check_output("pending_instrs", exp_q.size(), 0);
    check_output("pending_states", st_exp_q.size(), 0);

    // Reset while a load is stalled in MEMRD
    bus.opcode    = OP_LW;
    bus.mem_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_ready = 1'b0;
    @(posedge clk); #1;
    @(posedge clk);
    @(negedge clk);
    check_output("midrst_pre_state", int'(bus.state), int'(ST_MEMRD));
    check_output("midrst_pre_read", int'(bus.mem_read), 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_output("midrst_state", int'(bus.state), 0);
    check_output("midrst_outputs", all_outputs(), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_output("post_rst_fetch", int'(bus.state), int'(ST_FETCH));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
